serial_adder: RTL
=================

# serial_adder

Bit-serial N-bit adder: the addition counterpart to the lab's combinational full subtractor. It computes SUM = A + B + CIN one bit per clock, LSB first, using a single full-adder cell (sum = a^b^c, carry = ab|ac|bc) and a registered carry. A START/BUSY/DONE handshake sequences it. It is the sequential arithmetic block in the lab datapath, trading WIDTH cycles of latency for one adder cell.

## Interface

Parameters:
- WIDTH, default 8, operand and result width in bits; legal range is 2 or more.

Ports:
- CLK, input, 1, rising-edge clock.
- RST, input, 1, asynchronous active-high reset.
- START, input, 1, request to begin an addition; sampled only when the block is idle.
- A, input, WIDTH, augend; captured on the accepting edge.
- B, input, WIDTH, addend; captured on the accepting edge.
- CIN, input, 1, carry-in; captured on the accepting edge.
- BUSY, output, 1, high while an addition is in progress.
- DONE, output, 1, one-cycle pulse when the result is valid.
- SUM, output, WIDTH, result; holds its value between operations.
- COUT, output, 1, carry-out of the MSB; holds its value between operations.

## Operation

- States:
  - IDLE: BUSY=0.
  - RUN: BUSY=1.
- IDLE to RUN: on a rising edge with START=1.
  - Load shift register SA with A and SB with B.
  - Load the carry flop with CIN.
  - Clear the accumulator shift register SR.
  - Set the bit counter to 0.
- Each edge in RUN:
  - s = SA[0]^SB[0]^carry.
  - carry <= (SA[0]&SB[0]) | (SA[0]&carry) | (SB[0]&carry).
  - SA and SB shift right by one.
  - SR shifts right with s entering the MSB.
  - The counter increments.
- RUN to IDLE: on the edge where the counter goes from WIDTH-1 to WIDTH (the WIDTH-th bit edge).
  - SUM <= the final SR contents, with the last bit in the MSB.
  - COUT <= the final carry.
  - DONE is set for exactly one cycle.
- SUM and COUT change only at completion. Intermediate shift contents never appear on the outputs.
- START in RUN is ignored: no restart, no operand recapture.
- A, B and CIN may change freely after the accepting edge.
- Arithmetic is unsigned modulo 2^WIDTH, and COUT carries bit WIDTH.
  - Two's-complement subtraction uses B=~X with CIN=1, which gives A−X. COUT=1 means no borrow.
- Counter width: $clog2(WIDTH+1) bits, with no wrap inside an operation.
- Reset (asynchronous, any time, including mid-RUN):
  - State returns to IDLE.
  - BUSY=0, DONE=0, SUM=0, COUT=0.
  - Internal registers are cleared.
  - An in-flight operation is aborted, and no DONE is produced for it.
  - The first START accepted after RST deasserts behaves normally.

## Timing

- Accept edge k: START=1 while IDLE. BUSY=1 after edge k.
- Bits are processed on edges k+1 through k+WIDTH.
- After edge k+WIDTH:
  - SUM and COUT are valid.
  - DONE=1 and BUSY=0 for the cycle between edges k+WIDTH and k+WIDTH+1.
- Latency from accept to DONE is WIDTH cycles. Throughput is one result per WIDTH+1 cycles at most.
- Back-to-back: START=1 during the DONE cycle is accepted at edge k+WIDTH+1, since the block is IDLE then. DONE falls at that same edge.
- DONE is never high together with BUSY.
- DONE never stays high for two consecutive cycles.

## Test plan

- WIDTH=8, A=0x3C, B=0x5A, CIN=0, START pulsed at edge 0:
  - BUSY is high over edges 0–8.
  - DONE is high only after edge 8.
  - SUM=0x96, COUT=0.
- A=0xFF, B=0x01, CIN=0: SUM=0x00, COUT=1. Then A=0xFF, B=0xFF, CIN=1: SUM=0xFF, COUT=1.
- Subtraction via complement, A=0x05, B=~0x07=0xF8, CIN=1: SUM=0xFE, COUT=0 (borrow). A=0x07, B=~0x05, CIN=1: SUM=0x02, COUT=1.
- START held high and operands changed mid-RUN:
  - Only the first operands are used (0x3C+0x5A → 0x96).
  - Exactly one DONE appears before the next accept.
- RST asserted asynchronously at cycle 4 of a run:
  - All outputs go to 0 immediately, and no DONE appears.
  - A new START after release gives a correct result 8 cycles later.
- Back-to-back operations with START held continuously:
  - DONE pulses every 9 cycles.
  - Each SUM matches a reference model.
  - A 1000-vector random compare covers WIDTH=8 and WIDTH=16.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around one full-adder cell.
// Operands are captured on the accepting edge, then one bit is added per
// clock, LSB first, with the carry held in a flop. SUM/COUT update only when
// the last bit is processed, and DONE pulses for one cycle at that point.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Full-adder sum bit.
  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  // Full-adder carry bit (majority of the three inputs).
  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_finish;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_done;

  logic             w_s;
  logic             w_carry_next;
  logic [WIDTH-1:0] w_sr_next;

  // Single adder cell operating on the current LSBs and the stored carry.
  assign w_s          = fa_sum(r_sa[0], r_sb[0], r_carry);
  assign w_carry_next = fa_carry(r_sa[0], r_sb[0], r_carry);
  assign w_sr_next    = {w_s, r_sr[WIDTH-1:1]};

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus the accept/finish strobes that drive the datapath.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_state_next = S_RUN;
          w_accept     = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        // START is deliberately ignored here: no restart mid-operation.
        if (r_cnt == LAST) begin
          w_state_next = S_IDLE;
          w_finish     = 1'b1;
        end else begin
          w_state_next = S_RUN;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand/accumulator shift registers, carry flop and bit counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_sr    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_sa    <= A;
      r_sb    <= B;
      r_sr    <= '0;
      r_carry <= CIN;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
      r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
      r_sr    <= w_sr_next;
      r_carry <= w_carry_next;
      r_cnt   <= r_cnt + CW'(1);
    end else begin
      r_sa    <= r_sa;
      r_sb    <= r_sb;
      r_sr    <= r_sr;
      r_carry <= r_carry;
      r_cnt   <= r_cnt;
    end
  end

  // Result registers: updated only on the final bit so partial sums stay hidden.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_sum  <= w_sr_next;
        r_cout <= w_carry_next;
      end else begin
        r_sum  <= r_sum;
        r_cout <= r_cout;
      end
    end
  end

  assign BUSY = (r_state == S_RUN);
  assign DONE = r_done;
  assign SUM  = r_sum;
  assign COUT = r_cout;

endmodule
